// File: rtl/miob_pkg.sv
// miob_pkg: shared state encoding and IO window constants for the memory/IO bridge
package miob_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RAM_ACC = 2'd1,
      IO_ACC  = 2'd2,
      DONE    = 2'd3
   } state_t;
   localparam int IO_OFS_W = 12;
   localparam int CH_LSB   = 12;
   localparam int CH_MSB   = 15;
   localparam int CH_W     = CH_MSB - CH_LSB + 1;
   localparam int REGION_W = 4;
endpackage

// File: rtl/miob_wait_ctr.sv
// miob_wait_ctr: 8-bit loadable down-counter with zero flag, shared by RAM wait and IO timeout
module miob_wait_ctr (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] value,
   input  logic       en,
   output logic       zero
);
   logic [7:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (load) cnt <= value;
      else if (en && !zero) cnt <= cnt - 8'd1;
   assign zero = cnt == 8'd0;
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: registered, handshaked RAM / memory-mapped IO access engine
// Define MIOB_TIMEOUT_EN to abort IO accesses that see no ack within TIMEOUT cycles.
module mem_io_bridge
   import miob_pkg::*;
#(
   parameter int                  DW       = 32,
   parameter int                  AW       = 32,
   parameter int                  NCH      = 4,
   parameter logic [REGION_W-1:0] IO_BASE  = 4'hF,
   parameter int                  RAM_WAIT = 1,
   parameter int                  TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [AW-1:0]       addr_i,
   input  logic [DW-1:0]       wdata_i,
   input  logic [DW/8-1:0]     sel_i,
   output logic                busy_o,
   output logic                ready_o,
   output logic [DW-1:0]       rdata_o,
   output logic                err_o,
   output logic                ram_ce_o,
   output logic                ram_we_o,
   output logic [AW-1:0]       ram_addr_o,
   output logic [DW-1:0]       ram_data_o,
   output logic [DW/8-1:0]     ram_sel_o,
   input  logic [DW-1:0]       ram_data_i,
   output logic [NCH-1:0]      io_ce_o,
   output logic                io_we_o,
   output logic [IO_OFS_W-1:0] io_addr_o,
   output logic [DW-1:0]       io_data_o,
   input  logic [NCH*DW-1:0]   io_data_i,
   input  logic [NCH-1:0]      io_ack_i
);
   state_t            state, next;
   logic              lat_we;
   logic [AW-1:0]     lat_addr;
   logic [DW-1:0]     lat_wdata;
   logic [DW/8-1:0]   lat_sel;
   logic [DW-1:0]     rdata, next_rdata, io_rd;
   logic              err, next_err, go_done, ld, zero, expire, acked, is_io, ch_ok;
   logic [7:0]        ld_val;
   logic [CH_W-1:0]   ch;
   logic [NCH-1:0]    ch_hot;
   assign ch     = lat_addr[CH_MSB:CH_LSB];
   assign ch_hot = NCH'(1) << ch;
   assign acked  = |(io_ack_i & ch_hot);
   assign is_io  = addr_i[AW-1 -: REGION_W] == IO_BASE;
   assign ch_ok  = int'(addr_i[CH_MSB:CH_LSB]) < NCH;
`ifdef MIOB_TIMEOUT_EN
   assign expire = zero;
`else
   assign expire = 1'b0;
`endif
   always_comb begin
      io_rd = '0;
      for (int k = 0; k < NCH; k++)
         if (ch == CH_W'(k)) io_rd = io_data_i[k*DW +: DW];
   end
   miob_wait_ctr u_ctr (
      .clk   (clk),
      .rst   (rst),
      .load  (ld),
      .value (ld_val),
      .en    (state == RAM_ACC || state == IO_ACC),
      .zero  (zero)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= next;
   always_comb begin
      next       = state;
      ld         = 1'b0;
      ld_val     = 8'(RAM_WAIT - 1);
      go_done    = 1'b0;
      next_err   = 1'b0;
      next_rdata = '0;
      case (state)
         IDLE:
            if (req_i) begin
               if (!is_io) begin
                  next = RAM_ACC;
                  ld   = 1'b1;
               end else if (ch_ok) begin
                  next   = IO_ACC;
                  ld     = 1'b1;
                  ld_val = 8'(TIMEOUT - 1);
               end else begin
                  next     = DONE;
                  go_done  = 1'b1;
                  next_err = 1'b1;
               end
            end
         RAM_ACC:
            if (zero) begin
               next       = DONE;
               go_done    = 1'b1;
               next_rdata = lat_we ? '0 : ram_data_i;
            end
         IO_ACC:
            if (acked) begin
               next       = DONE;
               go_done    = 1'b1;
               next_rdata = lat_we ? '0 : io_rd;
            end else if (expire) begin
               next     = DONE;
               go_done  = 1'b1;
               next_err = 1'b1;
            end
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_sel   <= '0;
         rdata     <= '0;
         err       <= 1'b0;
      end else begin
         if (state == IDLE && req_i) begin
            lat_we    <= we_i;
            lat_addr  <= addr_i;
            lat_wdata <= wdata_i;
            lat_sel   <= sel_i;
         end
         if (go_done) begin
            rdata <= next_rdata;
            err   <= next_err;
         end
      end
   assign busy_o     = state != IDLE;
   assign ready_o    = state == DONE;
   assign rdata_o    = rdata;
   assign err_o      = err;
   assign ram_ce_o   = state == RAM_ACC;
   assign ram_we_o   = ram_ce_o & lat_we;
   assign ram_addr_o = ram_ce_o ? lat_addr : '0;
   assign ram_data_o = ram_ce_o ? lat_wdata : '0;
   assign ram_sel_o  = ram_ce_o ? lat_sel : '0;
   assign io_ce_o    = state == IO_ACC ? ch_hot : '0;
   assign io_we_o    = state == IO_ACC && lat_we;
   assign io_addr_o  = state == IO_ACC ? lat_addr[IO_OFS_W-1:0] : '0;
   assign io_data_o  = state == IO_ACC ? lat_wdata : '0;
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: table-driven and randomized checks of mem_io_bridge against a transaction-level model
module tb_mem_io_bridge;
   localparam int DW = 32, AW = 32, NCH = 4, RW = 3, TO = 8;
`ifdef MIOB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0, req_i = 1'b0, we_i = 1'b0;
   logic [AW-1:0] addr_i = '0;
   logic [DW-1:0] wdata_i = '0, ram_data_i = '0;
   logic [3:0] sel_i = '0;
   logic busy_o, ready_o, err_o, ram_ce_o, ram_we_o, io_we_o;
   logic [DW-1:0] rdata_o, ram_data_o, io_data_o;
   logic [AW-1:0] ram_addr_o;
   logic [3:0] ram_sel_o;
   logic [NCH-1:0] io_ce_o, io_ack_i = '0;
   logic [11:0] io_addr_o;
   logic [NCH*DW-1:0] io_data_i = '0;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   mem_io_bridge #(.DW(DW), .AW(AW), .NCH(NCH), .IO_BASE(4'hF), .RAM_WAIT(RW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .sel_i(sel_i), .busy_o(busy_o), .ready_o(ready_o), .rdata_o(rdata_o), .err_o(err_o),
      .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
      .ram_sel_o(ram_sel_o), .ram_data_i(ram_data_i), .io_ce_o(io_ce_o), .io_we_o(io_we_o),
      .io_addr_o(io_addr_o), .io_data_o(io_data_o), .io_data_i(io_data_i), .io_ack_i(io_ack_i)
   );
   typedef struct {
      logic        we;
      logic [31:0] addr, wdata;
      logic [3:0]  sel;
      logic [31:0] ram_data, slice;
      int          ack_d;
      int          exp_done;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic vec_t mk(input logic we, input logic [31:0] addr, wdata, input logic [3:0] sel,
                               input logic [31:0] rd, slice, input int ack_d, done, input logic err,
                               input logic [31:0] rdata);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel; v.ram_data = rd; v.slice = slice;
      v.ack_d = ack_d; v.exp_done = done; v.exp_err = err; v.exp_rdata = rdata;
      return v;
   endfunction
   // Reference: completion cycle (relative to the request edge), error and read data per transaction.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int ch = int'(v.addr[15:12]);
      if (v.addr[31:28] != 4'hF) begin
         r.exp_done = RW + 1; r.exp_err = 1'b0; r.exp_rdata = v.we ? 32'h0 : v.ram_data;
      end else if (ch >= NCH) begin
         r.exp_done = 1; r.exp_err = 1'b1; r.exp_rdata = 32'h0;
      end else if (v.ack_d >= 1 && (!TMO_EN || v.ack_d <= TO)) begin
         r.exp_done = v.ack_d + 1; r.exp_err = 1'b0; r.exp_rdata = v.we ? 32'h0 : v.slice;
      end else begin
         r.exp_done = TO + 1; r.exp_err = 1'b1; r.exp_rdata = 32'h0;
      end
      return r;
   endfunction
   task automatic run_access(input vec_t v, input bit spur);
      int ch = int'(v.addr[15:12]);
      bit ram_kind = v.addr[31:28] != 4'hF;
      bit io_kind = !ram_kind && ch < NCH;
      logic [3:0] hot = io_kind ? 4'(1 << ch) : 4'h0;
      logic [127:0] iod = {$urandom, $urandom, $urandom, $urandom};
      logic [3:0] noise;
      if (io_kind) iod[ch*32 +: 32] = v.slice;
      req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata; sel_i = v.sel;
      ram_data_i = v.ram_data; io_data_i = iod;
      @(posedge clk); #1;
      req_i = 1'b0; we_i = ~v.we; addr_i = $urandom; wdata_i = $urandom; sel_i = 4'($urandom);
      for (int n = 1; n <= v.exp_done + 1; n++) begin
         bit act = n < v.exp_done;
         bit live = n <= v.exp_done;
         chk("ctrl", {busy_o, ready_o, ram_ce_o, ram_we_o, io_ce_o, io_we_o},
             {live, n == v.exp_done, ram_kind && act, ram_kind && act && v.we,
              (io_kind && act) ? hot : 4'h0, io_kind && act && v.we});
         if (ram_kind && act) begin
            chk("ram_addr", ram_addr_o, v.addr);
            chk("ram_wdata", {ram_sel_o, ram_data_o}, {v.sel, v.wdata});
         end
         if (io_kind && act) chk("io_bus", {io_addr_o, io_data_o}, {v.addr[11:0], v.wdata});
         if (n >= v.exp_done) chk("result", {err_o, rdata_o}, {v.exp_err, v.exp_rdata});
         if (live) begin
            req_i = spur && n == 1;
            if (spur && n == 1) addr_i = 32'h0000_0040;
            noise = 4'($urandom);
            io_ack_i = (io_kind && act) ? ((n == v.ack_d) ? hot : (noise & ~hot)) : noise;
            @(posedge clk); #1;
         end
      end
      io_ack_i = '0; req_i = 1'b0;
   endtask
   vec_t tbl[$];
   vec_t v;
   initial begin
      tbl.push_back(mk(0, 32'h0000_0100, 32'h0, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, 4, 0, 32'hDEAD_BEEF));
      tbl.push_back(mk(1, 32'h0000_0200, 32'h0000_AB00, 4'b0010, 32'h5555_5555, 32'h0, 0, 4, 0, 32'h0));
      tbl.push_back(mk(0, 32'hF000_2010, 32'h0, 4'hF, 32'h0, 32'h1234_5678, 5, 6, 0, 32'h1234_5678));
      tbl.push_back(mk(0, 32'hF000_7000, 32'h0, 4'hF, 32'h0, 32'h0, 1, 1, 1, 32'h0));
      tbl.push_back(mk(1, 32'hF000_0FFC, 32'hA5A5_0001, 4'hF, 32'h0, 32'h0, 1, 2, 0, 32'h0));
      tbl.push_back(mk(0, 32'hF000_3ABC, 32'h0, 4'hF, 32'h0, 32'hCAFE_F00D, 2, 3, 0, 32'hCAFE_F00D));
      tbl.push_back(mk(0, 32'hE000_F000, 32'h0, 4'hF, 32'h0BAD_CAFE, 32'h0, 0, 4, 0, 32'h0BAD_CAFE));
      tbl.push_back(mk(0, 32'hF000_F000, 32'h0, 4'hF, 32'h0, 32'h0, 1, 1, 1, 32'h0));
`ifdef MIOB_TIMEOUT_EN
      tbl.push_back(mk(0, 32'hF000_1000, 32'h0, 4'hF, 32'h0, 32'h7777_0000, 0, TO + 1, 1, 32'h0));
      tbl.push_back(mk(0, 32'hF000_1004, 32'h0, 4'hF, 32'h0, 32'h7777_0001, TO, TO + 1, 0, 32'h7777_0001));
`endif
      #12;
      chk("reset_ctrl", {busy_o, ready_o, err_o, ram_ce_o, ram_we_o, io_ce_o, io_we_o, io_addr_o}, '0);
      chk("reset_data", {rdata_o, ram_addr_o, ram_data_o, ram_sel_o}, '0);
      chk("reset_io_data", io_data_o, '0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      foreach (tbl[i]) run_access(tbl[i], i == 2 || i == 3);
      for (int i = 0; i < 40; i++) begin
         int r = $urandom_range(0, 9);
         v.we = 1'($urandom); v.sel = 4'($urandom); v.wdata = $urandom;
         v.ram_data = $urandom; v.slice = $urandom;
         if (r < 5) v.addr = {4'($urandom_range(0, 14)), 28'($urandom)};
         else if (r < 9) v.addr = {4'hF, 12'($urandom), 4'($urandom_range(0, NCH - 1)), 12'($urandom)};
         else v.addr = {4'hF, 12'($urandom), 4'($urandom_range(NCH, 15)), 12'($urandom)};
         v.ack_d = TMO_EN ? int'($urandom_range(1, TO + 3)) : int'($urandom_range(1, 12));
         run_access(model(v), $urandom_range(0, 3) == 0);
      end
      run_access(mk(0, 32'h0000_0010, 32'h0, 4'hF, 32'h600D_0001, 32'h0, 0, 4, 0, 32'h600D_0001), 0);
      begin
         bit quiet = 1'b1;
         int nw = TMO_EN ? 3 : 300;
         req_i = 1'b1; we_i = 1'b0; addr_i = 32'hF000_1004;
         @(posedge clk); #1 req_i = 1'b0;
         for (int n = 0; n < nw; n++) begin
            io_ack_i = 4'($urandom) & 4'b1101;
            if (ready_o || !busy_o || io_ce_o != 4'b0010) quiet = 1'b0;
            @(posedge clk); #1;
         end
         chk("io_wait_no_ready", quiet, 1'b1);
         #3 rst = 1'b0;
         #1;
         chk("async_reset_ctrl", {busy_o, ready_o, err_o, ram_ce_o, io_ce_o, io_we_o, io_addr_o}, '0);
         chk("async_reset_rdata", rdata_o, '0);
         io_ack_i = 4'b0010;
         @(posedge clk); #1 rst = 1'b1;
         quiet = 1'b1;
         for (int n = 0; n < 4; n++) begin
            if (ready_o || busy_o) quiet = 1'b0;
            @(posedge clk); #1;
         end
         io_ack_i = '0;
         chk("abandoned_no_ready", quiet, 1'b1);
      end
      run_access(mk(1, 32'hF000_3008, 32'h0102_0304, 4'h3, 32'h0, 32'h0, 3, 4, 0, 32'h0), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
